// File: rtl/hit_monitor_pkg.sv
// Shared types and defaults for the hit_monitor statistics stage.
// Holds the tracking-state enum and the next-state rule used by the top level.
package hit_monitor_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int GAP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } hm_state_t;

  // A clear always returns to IDLE and discards any coincident hit.
  function automatic hm_state_t hm_next(input hm_state_t cur, input logic hit, input logic clr);
    hm_state_t nxt;
    nxt = cur;
    if (clr) begin
      nxt = IDLE;
    end else if (hit) begin
      case (cur)
        IDLE:    nxt = ARMED;
        ARMED:   nxt = TRACK;
        TRACK:   nxt = TRACK;
        default: nxt = IDLE;
      endcase
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hit_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// The clear has priority over the load, which has priority over the increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_VAL  = {W{1'b1}};
  localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
  localparam logic [W-1:0] ONE_VAL  = W'(1'b1);

  logic [W-1:0] value_r;

  // counter register: clear, load, or saturating increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_r <= ZERO_VAL;
    end else if (clr) begin
      value_r <= ZERO_VAL;
    end else if (load) begin
      value_r <= ONE_VAL;
    end else if (inc && (value_r != MAX_VAL)) begin
      value_r <= value_r + ONE_VAL;
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/hit_monitor.sv
// Match statistics downstream of the sequence detector: saturating match count,
// last/minimum spacing between matches and a one-shot threshold interrupt.
module hit_monitor
  import hit_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hit,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] count,
  output logic [GAP_W-1:0] gap_last,
  output logic [GAP_W-1:0] gap_min,
  output logic             gap_valid,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [GAP_W-1:0] GAP_MAX  = {GAP_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};

  hm_state_t        state_r;
  hm_state_t        state_nxt_s;
  logic [CNT_W-1:0] count_s;
  logic [GAP_W-1:0] gap_cnt_s;
  logic [GAP_W-1:0] gap_last_r;
  logic [GAP_W-1:0] gap_min_r;
  logic [GAP_W-1:0] gap_min_nxt_s;
  logic             gap_valid_r;
  logic             irq_r;
  logic             irq_set_s;

  sat_counter #(.W(CNT_W)) u_count (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .load   (1'b0),
    .inc    (hit),
    .value  (count_s)
  );

  // Reloaded on every hit, so at the next hit it holds the spacing in cycles.
  sat_counter #(.W(GAP_W)) u_gap (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .load   (hit),
    .inc    (1'b1),
    .value  (gap_cnt_s)
  );

  assign state_nxt_s = hm_next(state_r, hit, clr);

  // count+1 cannot wrap while count is below saturation, so thresh==0 never matches
  assign irq_set_s = hit && (count_s != CNT_MAX) && ((count_s + CNT_ONE) == thresh)
                     && (thresh != CNT_ZERO);

  // running minimum candidate for a hit in TRACK
  always_comb begin
    gap_min_nxt_s = gap_min_r;
    if (gap_cnt_s < gap_min_r) begin
      gap_min_nxt_s = gap_cnt_s;
    end else begin
      gap_min_nxt_s = gap_min_r;
    end
  end

  // tracking FSM with registered gap statistics and interrupt
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      gap_last_r  <= GAP_ZERO;
      gap_min_r   <= GAP_MAX;
      gap_valid_r <= 1'b0;
      irq_r       <= 1'b0;
    end else if (clr) begin
      state_r     <= IDLE;
      gap_last_r  <= GAP_ZERO;
      gap_min_r   <= GAP_MAX;
      gap_valid_r <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      gap_valid_r <= (state_nxt_s == TRACK);
      irq_r       <= irq_set_s;
      if (hit) begin
        case (state_r)
          IDLE: begin
            gap_last_r <= gap_last_r;
            gap_min_r  <= gap_min_r;
          end
          ARMED: begin
            gap_last_r <= gap_cnt_s;
            gap_min_r  <= gap_cnt_s;
          end
          TRACK: begin
            gap_last_r <= gap_cnt_s;
            gap_min_r  <= gap_min_nxt_s;
          end
          default: begin
            gap_last_r <= GAP_ZERO;
            gap_min_r  <= GAP_MAX;
          end
        endcase
      end else begin
        gap_last_r <= gap_last_r;
        gap_min_r  <= gap_min_r;
      end
    end
  end

  assign count     = count_s;
  assign gap_last  = gap_last_r;
  assign gap_min   = gap_min_r;
  assign gap_valid = gap_valid_r;
  assign irq       = irq_r;

endmodule
